// File: rtl/wei_ctrl_pkg.sv
// Shared definitions for the weight-configuration control blocks.
// Holds the state encoding and the width helpers used by the DISWEI side.
package wei_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_PREFILL = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DONE    = 3'd4
   } wei_state_e;

   function automatic int clog2(input int value);
      int res_v;
      res_v = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) res_v = i + 32'sd1;
      end
      return res_v;
   endfunction

   // Index width never collapses to zero, so a single-PEC build still has a port.
   function automatic int pec_w_f(input int num_pec);
      int w_v;
      w_v = clog2(num_pec);
      return (w_v < 32'sd1) ? 32'sd1 : w_v;
   endfunction

   function automatic int tot_w_f(input int num_pec, input int round_w);
      return pec_w_f(num_pec) + 32'sd1 + round_w;
   endfunction

endpackage

// File: rtl/wei_job_cnt.sv
// Job bookkeeping for the weight scheduler: PEC index, round, fetch and grant
// counters, plus the terminal flags the FSM steers by.
module wei_job_cnt
   import wei_ctrl_pkg::*;
#(
   parameter int PIPE_DEPTH = 3,
   parameter int PEC_W      = 6,
   parameter int ROUND_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [PEC_W:0]               cfg_np,
   input  logic [PEC_W+ROUND_W:0]       cfg_total,
   input  logic                         fetch_inc,
   input  logic                         grant_inc,
   output logic [PEC_W-1:0]             idpec,
   output logic [ROUND_W-1:0]           round,
   output logic                         fetch_left,
   output logic                         prefill_last,
   output logic                         grant_last
);

   localparam int TOT_W = PEC_W + 1 + ROUND_W;
   localparam logic [TOT_W-1:0]   CNT_ONE = TOT_W'(1'b1);
   localparam logic [TOT_W-1:0]   PD_CNT  = TOT_W'(PIPE_DEPTH);
   localparam logic [PEC_W:0]     NP_ONE  = (PEC_W + 1)'(1'b1);
   localparam logic [PEC_W-1:0]   IDX_ONE = PEC_W'(1'b1);
   localparam logic [ROUND_W-1:0] RND_ONE = ROUND_W'(1'b1);

   logic [PEC_W:0]     np_r;
   logic [TOT_W-1:0]   total_r;
   logic [PEC_W-1:0]   idpec_r;
   logic [ROUND_W-1:0] round_r;
   logic [TOT_W-1:0]   fetch_cnt_r;
   logic [TOT_W-1:0]   grant_cnt_r;
   logic [TOT_W-1:0]   prefill_tgt_s;

   // Counters: latched on a legal start, then stepped by fetch and grant events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         np_r        <= {(PEC_W + 1){1'b0}};
         total_r     <= {TOT_W{1'b0}};
         idpec_r     <= {PEC_W{1'b0}};
         round_r     <= {ROUND_W{1'b0}};
         fetch_cnt_r <= {TOT_W{1'b0}};
         grant_cnt_r <= {TOT_W{1'b0}};
      end else if (load) begin
         np_r        <= cfg_np;
         total_r     <= cfg_total;
         idpec_r     <= PEC_W'(cfg_np - NP_ONE);
         round_r     <= {ROUND_W{1'b0}};
         fetch_cnt_r <= {TOT_W{1'b0}};
         grant_cnt_r <= {TOT_W{1'b0}};
      end else begin
         if (fetch_inc) fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
         if (grant_inc) begin
            grant_cnt_r <= grant_cnt_r + CNT_ONE;
            if (idpec_r == {PEC_W{1'b0}}) begin
               idpec_r <= PEC_W'(np_r - NP_ONE);
               round_r <= round_r + RND_ONE;
            end else begin
               idpec_r <= idpec_r - IDX_ONE;
            end
         end
      end
   end

   // Short jobs prefill only as many words as they will ever consume.
   assign prefill_tgt_s = (total_r < PD_CNT) ? total_r : PD_CNT;

   assign idpec        = idpec_r;
   assign round        = round_r;
   assign fetch_left   = (fetch_cnt_r < total_r);
   assign prefill_last = ((fetch_cnt_r + CNT_ONE) == prefill_tgt_s);
   assign grant_last   = ((grant_cnt_r + CNT_ONE) == total_r);

endmodule

// File: rtl/ctrl_wei_sched.sv
// Weight-configuration controller: prefills the GBFWEI fetch pipeline, then
// hands weight words to the active PECs one at a time, highest index first.
module ctrl_wei_sched
   import wei_ctrl_pkg::*;
#(
   parameter int NUM_PEC    = 48,
   parameter int PIPE_DEPTH = 3,
   parameter int ROUND_W    = 8,
   parameter int PEC_W      = pec_w_f(NUM_PEC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PEC_W:0]     cfg_num_pec,
   input  logic [ROUND_W-1:0] cfg_num_round,
   input  logic               diswei_rdy_wei,
   input  logic [NUM_PEC-1:0] pec_get_wei,
   output logic [NUM_PEC-1:0] pec_rdy_wei,
   output logic               pls_fetch,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic               proto_err
);

   localparam int TOT_W = PEC_W + 1 + ROUND_W;
   localparam logic [PEC_W:0] NP_MAX = (PEC_W + 1)'(NUM_PEC);

   wei_state_e         state_r, state_nxt_s;
   logic [NUM_PEC-1:0] pec_rdy_r, pec_rdy_nxt_s;
   logic               done_r, done_nxt_s;
   logic               cfg_err_r, cfg_err_nxt_s;
   logic               proto_err_r, proto_err_nxt_s;
   logic               pls_fetch_s, fetch_inc_s, grant_inc_s;
   logic               start_s, cfg_ok_s, load_s, grant_s, stray_s;
   logic [TOT_W-1:0]   total_s;
   logic [NUM_PEC-1:0] sel_mask_s;
   logic [PEC_W-1:0]   idpec_s;
   logic [ROUND_W-1:0] round_s;
   logic               fetch_left_s, prefill_last_s, grant_last_s;

   assign start_s  = start && (state_r == ST_IDLE);
   assign cfg_ok_s = (cfg_num_pec != {(PEC_W + 1){1'b0}}) && (cfg_num_pec <= NP_MAX) &&
                     (cfg_num_round != {ROUND_W{1'b0}});
   assign load_s   = start_s && cfg_ok_s;
   assign total_s  = TOT_W'(cfg_num_pec) * TOT_W'(cfg_num_round);

   // A grant counts only on the selected bit while WAIT; any other strobe is stray.
   assign sel_mask_s = NUM_PEC'(1'b1) << idpec_s;
   assign grant_s    = (state_r == ST_WAIT) && (|(pec_get_wei & sel_mask_s));
   assign stray_s    = (state_r == ST_WAIT) ? (|(pec_get_wei & ~sel_mask_s)) : (|pec_get_wei);

   wei_job_cnt #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .PEC_W      (PEC_W),
      .ROUND_W    (ROUND_W)
   ) u_job_cnt (
      .clk          (clk),
      .rst          (rst),
      .load         (load_s),
      .cfg_np       (cfg_num_pec),
      .cfg_total    (total_s),
      .fetch_inc    (fetch_inc_s),
      .grant_inc    (grant_inc_s),
      .idpec        (idpec_s),
      .round        (round_s),
      .fetch_left   (fetch_left_s),
      .prefill_last (prefill_last_s),
      .grant_last   (grant_last_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Next-state decode, fetch pulse and next values of the registered outputs.
   always_comb begin
      state_nxt_s   = state_r;
      pec_rdy_nxt_s = pec_rdy_r;
      done_nxt_s    = 1'b0;
      pls_fetch_s   = 1'b0;
      fetch_inc_s   = 1'b0;
      grant_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_s) state_nxt_s = ST_PREFILL;
            else        state_nxt_s = ST_IDLE;
         end
         ST_PREFILL: begin
            pls_fetch_s = 1'b1;
            fetch_inc_s = 1'b1;
            if (prefill_last_s) state_nxt_s = ST_ISSUE;
            else                state_nxt_s = ST_PREFILL;
         end
         ST_ISSUE: begin
            if (diswei_rdy_wei) begin
               pec_rdy_nxt_s = sel_mask_s;
               state_nxt_s   = ST_WAIT;
            end else begin
               state_nxt_s   = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (grant_s) begin
               // Top up the pipeline only while words remain to be fetched.
               pls_fetch_s   = fetch_left_s;
               fetch_inc_s   = fetch_left_s;
               grant_inc_s   = 1'b1;
               pec_rdy_nxt_s = {NUM_PEC{1'b0}};
               if (grant_last_s) begin
                  state_nxt_s = ST_DONE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_ISSUE;
               end
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            pec_rdy_nxt_s = {NUM_PEC{1'b0}};
         end
      endcase

      cfg_err_nxt_s = start_s && !cfg_ok_s;
      if (load_s) proto_err_nxt_s = stray_s;
      else        proto_err_nxt_s = proto_err_r | stray_s;
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pec_rdy_r   <= {NUM_PEC{1'b0}};
         done_r      <= 1'b0;
         cfg_err_r   <= 1'b0;
         proto_err_r <= 1'b0;
      end else begin
         pec_rdy_r   <= pec_rdy_nxt_s;
         done_r      <= done_nxt_s;
         cfg_err_r   <= cfg_err_nxt_s;
         proto_err_r <= proto_err_nxt_s;
      end
   end

   assign pec_rdy_wei = pec_rdy_r;
   assign pls_fetch   = pls_fetch_s;
   assign busy        = (state_r != ST_IDLE);
   assign done        = done_r;
   assign cfg_err     = cfg_err_r;
   assign proto_err   = proto_err_r;

endmodule
